serial_tx16: RTL and testbench

- Bit-serial transmitter for 16-bit words.
- Accepts a parallel word over a valid/ready handshake.
- Emits it on a single idle-high line as an asynchronous frame: start bit, 16 data bits LSB first, optional parity, stop bit(s).
- Sits between the CPU/IO-mapped register bank and an external serial pin.
- Peer of the team's planned 16-bit serial receiver; both share frame constants.

---
 rtl/serial_pkg.sv | 21 ++
 rtl/serial_bit_timer.sv | 34 +++
 rtl/serial_tx16.sv | 150 +++++++++++++++
 tb/tb_serial_tx16.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared constants for the 16-bit serial transmitter and receiver pair.
package serial_pkg;

  localparam int WORD_W = 16;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic even_par(input logic [WORD_W-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period counter: pulses o_bit_done on the last cycle of each bit.
module serial_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_restart,
  output logic o_bit_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("serial_bit_timer: CLKS_PER_BIT must be >= 2");
  end

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_restart) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_bit_done = (r_cnt == LAST);

endmodule

// File: rtl/serial_tx16.sv
// 16-bit async-frame serial transmitter, LSB first, idle-high line.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit after bit 15.
module serial_tx16
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_line,
  output logic              busy
);

  if (CLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
    $error("serial_tx16: illegal CLKS_PER_BIT or STOP_BITS");
  end

  localparam logic [3:0] LAST_BIT  = 4'd15;
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WORD_W-1:0] r_shift;
  logic [WORD_W-1:0] w_shift_nxt;
  logic [3:0]        r_bit;
  logic [3:0]        w_bit_nxt;
  logic              r_line;
  logic              w_line_nxt;
  logic              w_restart;
  logic              w_bit_done;
  logic              w_par;

  // Timer sits at zero while idle so START gets a full bit period.
  assign w_restart = (r_state == IDLE);

  serial_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_restart (w_restart),
    .o_bit_done(w_bit_done)
  );

`ifdef SERIAL_TX_PARITY_EN
  logic r_par;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_par <= 1'b0;
    end else if (r_state == IDLE && tx_valid) begin
      r_par <= even_par(tx_data);
    end
  end

  assign w_par = r_par;
`else
  assign w_par = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit;
    unique case (r_state)
      IDLE: begin
        if (tx_valid) begin
          w_state_nxt = START;
          w_shift_nxt = tx_data;
          w_bit_nxt   = '0;
        end
      end
      START: begin
        if (w_bit_done) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_bit_done) begin
          w_shift_nxt = {1'b0, r_shift[WORD_W-1:1]};
          if (r_bit == LAST_BIT) begin
            w_bit_nxt = '0;
`ifdef SERIAL_TX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end else begin
            w_bit_nxt = r_bit + 4'd1;
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (w_bit_done) begin
          w_state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (w_bit_done) begin
          if (r_bit == LAST_STOP) begin
            w_state_nxt = IDLE;
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt = r_bit + 4'd1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_bit_nxt   = '0;
      end
    endcase
  end

  // Line level is decoded from the next state so the pin is a flop.
  always_comb begin
    w_line_nxt = IDLE_LEVEL;
    unique case (1'b1)
      (w_state_nxt == START):  w_line_nxt = START_LEVEL;
      (w_state_nxt == DATA):   w_line_nxt = w_shift_nxt[0];
      (w_state_nxt == PARITY): w_line_nxt = w_par;
      default:                 w_line_nxt = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_line  <= IDLE_LEVEL;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_bit   <= w_bit_nxt;
      r_line  <= w_line_nxt;
    end
  end

  assign tx_ready = (r_state == IDLE);
  assign busy     = ~tx_ready;
  assign tx_line  = r_line;

endmodule

// File: tb/tb_serial_tx16.sv
// Self-checking bench for serial_tx16: vector table, random words,
// back-to-back, data stability, mid-frame reset and two-stop-bit build.
module tb_serial_tx16;

  localparam int CA = 4;
  localparam int SA = 1;
  localparam int CB = 2;
  localparam int SB = 2;
`ifdef SERIAL_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int LEN_A = (1 + 16 + PB + SA) * CA;
  localparam int LEN_B = (1 + 16 + PB + SB) * CB;
  localparam int PIDX  = 17 * CA + CA / 2;

  typedef bit bitq_t[$];

  typedef struct {
    logic [15:0] w;
    logic        exp_par;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a_data = '0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic        a_line;
  logic        a_busy;
  logic [15:0] b_data = '0;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic        b_line;
  logic        b_busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_tx16 #(.CLKS_PER_BIT(CA), .STOP_BITS(SA)) dut_a (
    .clock(clk), .reset_n(rst_n), .tx_data(a_data), .tx_valid(a_valid),
    .tx_ready(a_ready), .tx_line(a_line), .busy(a_busy)
  );

  serial_tx16 #(.CLKS_PER_BIT(CB), .STOP_BITS(SB)) dut_b (
    .clock(clk), .reset_n(rst_n), .tx_data(b_data), .tx_valid(b_valid),
    .tx_ready(b_ready), .tx_line(b_line), .busy(b_busy)
  );

  // Expected per-cycle line levels for one frame.
  function automatic bitq_t frame_bits(input logic [15:0] w, input int c,
                                       input int s);
    bitq_t q;
    bit    lvl;
    for (int k = 0; k < 1 + 16 + PB + s; k++) begin
      if (k == 0) lvl = 1'b0;
      else if (k <= 16) lvl = w[k-1];
      else if (PB == 1 && k == 17) lvl = ^w;
      else lvl = 1'b1;
      repeat (c) q.push_back(lvl);
    end
    return q;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic hs_a(input logic [15:0] w);
    int t = 0;
    while (a_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("ready_timeout", 32'(t >= 200), 0);
    a_data  = w;
    a_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  // Entered on the negedge right after the handshake edge.
  task automatic frame_a(input logic [15:0] w, input string nm,
                         output logic par_seen);
    bitq_t q = frame_bits(w, CA, SA);
    int    n = 0;
    int    bad = 0;
    logic  e;
    par_seen = 1'bx;
    while (a_ready !== 1'b1 && n < LEN_A + 20) begin
      e = (n < q.size()) ? q[n] : 1'b1;
      if (a_line !== e || a_busy !== 1'b1) bad++;
      if (n == PIDX) par_seen = a_line;
      n++;
      @(negedge clk);
    end
    chk({nm, " len"}, n, LEN_A);
    chk({nm, " line"}, bad, 0);
    chk({nm, " idle"}, {30'd0, a_line, a_busy}, 2'b10);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[6];
    logic        ps;
    logic [15:0] w;
    bitq_t       qb;
    int          n;
    int          bad;
    int          lows;
    logic        eb;

    tbl[0] = '{16'hA5C3, 1'b0};
    tbl[1] = '{16'h0001, 1'b1};
    tbl[2] = '{16'h0003, 1'b0};
    tbl[3] = '{16'hFFFF, 1'b0};
    tbl[4] = '{16'h0000, 1'b0};
    tbl[5] = '{16'h8000, 1'b1};

    repeat (3) @(negedge clk);
    chk("reset a", {29'd0, a_line, a_ready, a_busy}, 3'b110);
    chk("reset b", {29'd0, b_line, b_ready, b_busy}, 3'b110);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      hs_a(tbl[i].w);
      frame_a(tbl[i].w, $sformatf("vec %h", tbl[i].w), ps);
      chk($sformatf("par/stop slot %h", tbl[i].w), 32'(ps),
          (PB == 1) ? 32'(tbl[i].exp_par) : 32'd1);
    end

    for (int r = 0; r < 6; r++) begin
      w = 16'($urandom);
      hs_a(w);
      frame_a(w, $sformatf("rand %h", w), ps);
    end

    // Data changed after capture must not reach the line.
    hs_a(16'h1234);
    fork
      begin
        @(negedge clk);
        a_data = 16'h0000;
      end
    join_none
    frame_a(16'h1234, "stable 1234", ps);

    // Back-to-back with tx_valid held high.
    a_data  = 16'h0001;
    a_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fork
      begin
        a_data = 16'hFFFF;
        repeat (LEN_A + 1) @(negedge clk);
        a_valid = 1'b0;
      end
    join_none
    frame_a(16'h0001, "b2b first", ps);
    @(negedge clk);
    frame_a(16'hFFFF, "b2b second", ps);
    lows = 0;
    for (int k = 0; k < 100; k++) begin
      if (a_line !== 1'b1 || a_ready !== 1'b1) lows++;
      @(negedge clk);
    end
    chk("no third frame", lows, 0);

    // Asynchronous reset in the middle of data bit 7.
    hs_a(16'hBEEF);
    repeat (CA * 8 + 1) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async reset", {29'd0, a_line, a_ready, a_busy}, 3'b110);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    hs_a(16'h00FF);
    frame_a(16'h00FF, "after reset 00FF", ps);

    // Two stop bits at two clocks per bit.
    b_data  = 16'hA5C3;
    b_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_valid = 1'b0;
    qb  = frame_bits(16'hA5C3, CB, SB);
    n   = 0;
    bad = 0;
    while (b_ready !== 1'b1 && n < LEN_B + 20) begin
      eb = (n < qb.size()) ? qb[n] : 1'b1;
      if (b_line !== eb || b_busy !== 1'b1) bad++;
      n++;
      @(negedge clk);
    end
    chk("stop2 len", n, LEN_B);
    chk("stop2 line", bad, 0);
    chk("stop2 idle", {30'd0, b_line, b_busy}, 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
